// File: rtl/controlador_ataque_if.sv
// Bundle for the attack engine.
// It carries the game-state enable, the shot request, the switch coordinates and the
// confirmed ship map into the engine. It carries the attack matrix, the lives and the
// status LEDs back out. The game FSM drives the master side; the attack engine is the slave.
interface controlador_ataque_if;
    logic       enable;
    logic       confirmar;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic [2:0] vida;
    logic       LED_R, LED_G, LED_B;
    logic       vitoria, derrota;

    modport master (
        output enable, confirmar, coordColuna, coordLinha,
        output mapa0, mapa1, mapa2, mapa3, mapa4,
        input  matriz0, matriz1, matriz2, matriz3, matriz4,
        input  vida, LED_R, LED_G, LED_B, vitoria, derrota
    );

    modport slave (
        input  enable, confirmar, coordColuna, coordLinha,
        input  mapa0, mapa1, mapa2, mapa3, mapa4,
        output matriz0, matriz1, matriz2, matriz3, matriz4,
        output vida, LED_R, LED_G, LED_B, vitoria, derrota
    );
endinterface

// File: rtl/controlador_ataque.sv
// Attack-phase engine of the battleship game.
// It keeps the shot and hit history, the lives and the win/lose state. It drives the
// attack matrix and the active-low RGB status LEDs.
// Every output is a second register stage fed from the game state. A shot confirmed at
// edge k is evaluated at edge k+1 and becomes visible at edge k+2.
// Optional build macro REVELAR_MAPA_EN: while the game is in progress, unhit ship cells
// are lit in antiphase to the miss blink. This is a debug/demo aid.
//
// state    | meaning
// INATIVO  | not in attack phase; history cleared, lives reloaded
// ESPERA   | waiting for a confirm pulse
// AVALIA   | one cycle: classify the latched shot, update history
// FEEDBACK | per-shot colour held for FEEDBACK_CICLOS cycles
// VITORIA  | all ships hit; held until enable drops
// DERROTA  | lives exhausted; full map revealed; held until enable drops
module controlador_ataque #(
    parameter int VIDA_INICIAL    = 3,
    parameter int FEEDBACK_CICLOS = 381,
    parameter int PISCA_CICLOS    = 190
) (
    input logic clock,
    input logic reset,
    controlador_ataque_if.slave bus
);
    localparam int FB_W = $clog2(FEEDBACK_CICLOS + 1);
    localparam int PS_W = $clog2(PISCA_CICLOS + 1);
    localparam logic [2:0] VIDA_INI = 3'(VIDA_INICIAL);

    typedef enum logic [2:0] {INATIVO, ESPERA, AVALIA, FEEDBACK, VITORIA, DERROTA} estado_t;
    typedef enum logic [1:0] {COR_NENHUMA, COR_R, COR_G, COR_B} cor_t;

    estado_t         estado_q, estado_d;
    logic [34:0]     tiros_q, tiros_d;
    logic [34:0]     acertos_q, acertos_d;
    logic [2:0]      vida_q, vida_d;
    cor_t            cor_q, cor_d;
    logic [2:0]      col_q, lin_q;
    logic [FB_W-1:0] fb_cnt_q;
    logic [PS_W-1:0] pisca_cnt_q;
    logic            pisca_q;

    logic [34:0]     matriz_q;
    logic [2:0]      vida_exib_q;
    logic            led_r_q, led_g_q, led_b_q;
    logic            vitoria_q, derrota_q;

    // Cell (c, r) lives at bit c*7+r of every flattened 35-bit mask.
    logic [34:0]     mapa, alvo, erros, vista;
    logic            valido;
    logic [5:0]      idx;

    // Shot classification for AVALIA, plus the in-game matrix picture.
    always_comb begin
        mapa      = {bus.mapa4, bus.mapa3, bus.mapa2, bus.mapa1, bus.mapa0};
        valido    = (col_q <= 3'd4) && (lin_q <= 3'd6);
        idx       = 6'(col_q) * 6'd7 + 6'(lin_q);
        alvo      = valido ? (35'd1 << idx) : '0;
        tiros_d   = tiros_q;
        acertos_d = acertos_q;
        vida_d    = vida_q;
        cor_d     = COR_B;
        if (alvo == '0 || (alvo & tiros_q) != '0) begin
            cor_d = COR_B;
        end else if ((alvo & mapa) != '0) begin
            tiros_d   = tiros_q | alvo;
            acertos_d = acertos_q | alvo;
            cor_d     = COR_G;
        end else begin
            tiros_d = tiros_q | alvo;
            vida_d  = (vida_q == 3'd0) ? 3'd0 : vida_q - 3'd1;
            cor_d   = COR_R;
        end

        if (cor_d == COR_R && vida_d == 3'd0)
            estado_d = DERROTA;
        else if (acertos_d == mapa && mapa != '0)
            estado_d = VITORIA;
        else
            estado_d = FEEDBACK;

        erros = tiros_q & ~acertos_q;
        vista = acertos_q | (erros & {35{pisca_q}});
`ifdef REVELAR_MAPA_EN
        vista = vista | (mapa & ~tiros_q & {35{~pisca_q}});
`endif
    end

    // Free-running blink; only a hard reset restarts its phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            pisca_cnt_q <= '0;
            pisca_q     <= 1'b0;
        end else if (pisca_cnt_q == PS_W'(PISCA_CICLOS - 1)) begin
            pisca_cnt_q <= '0;
            pisca_q     <= ~pisca_q;
        end else begin
            pisca_cnt_q <= pisca_cnt_q + 1'b1;
        end
    end

    // Game FSM, with the output stage registered from the current game state.
    always_ff @(posedge clock) begin
        if (reset || !bus.enable) begin
            estado_q    <= INATIVO;
            tiros_q     <= '0;
            acertos_q   <= '0;
            vida_q      <= VIDA_INI;
            cor_q       <= COR_NENHUMA;
            col_q       <= '0;
            lin_q       <= '0;
            fb_cnt_q    <= '0;
            matriz_q    <= '0;
            vida_exib_q <= VIDA_INI;
            led_r_q     <= 1'b1;
            led_g_q     <= 1'b1;
            led_b_q     <= 1'b1;
            vitoria_q   <= 1'b0;
            derrota_q   <= 1'b0;
        end else begin
            matriz_q    <= '0;
            vida_exib_q <= vida_q;
            led_r_q     <= 1'b1;
            led_g_q     <= 1'b1;
            led_b_q     <= 1'b1;
            vitoria_q   <= 1'b0;
            derrota_q   <= 1'b0;
            case (estado_q)
                ESPERA, AVALIA: matriz_q <= vista;
                FEEDBACK: begin
                    matriz_q <= vista;
                    led_r_q  <= (cor_q != COR_R);
                    led_g_q  <= (cor_q != COR_G);
                    led_b_q  <= (cor_q != COR_B);
                end
                VITORIA: begin
                    matriz_q  <= acertos_q;
                    led_g_q   <= 1'b0;
                    vitoria_q <= 1'b1;
                end
                DERROTA: begin
                    matriz_q  <= mapa;
                    led_r_q   <= 1'b0;
                    derrota_q <= 1'b1;
                end
                default: ;
            endcase

            case (estado_q)
                INATIVO: estado_q <= ESPERA;
                ESPERA: begin
                    if (bus.confirmar) begin
                        col_q    <= bus.coordColuna;
                        lin_q    <= bus.coordLinha;
                        estado_q <= AVALIA;
                    end
                end
                AVALIA: begin
                    tiros_q   <= tiros_d;
                    acertos_q <= acertos_d;
                    vida_q    <= vida_d;
                    cor_q     <= cor_d;
                    fb_cnt_q  <= FB_W'(FEEDBACK_CICLOS - 1);
                    estado_q  <= estado_d;
                end
                FEEDBACK: begin
                    if (fb_cnt_q == '0) begin
                        cor_q    <= COR_NENHUMA;
                        estado_q <= ESPERA;
                    end else begin
                        fb_cnt_q <= fb_cnt_q - 1'b1;
                    end
                end
                VITORIA, DERROTA: ;
                default: estado_q <= INATIVO;
            endcase
        end
    end

    assign bus.matriz0 = matriz_q[6:0];
    assign bus.matriz1 = matriz_q[13:7];
    assign bus.matriz2 = matriz_q[20:14];
    assign bus.matriz3 = matriz_q[27:21];
    assign bus.matriz4 = matriz_q[34:28];
    assign bus.vida    = vida_exib_q;
    assign bus.LED_R   = led_r_q;
    assign bus.LED_G   = led_g_q;
    assign bus.LED_B   = led_b_q;
    assign bus.vitoria = vitoria_q;
    assign bus.derrota = derrota_q;
endmodule
